// File: rtl/maestro_hci_package.sv
// Shared types and constants for the maestro HCI mode-switch controller.
//   mode_sw_state_t : FSM state encoding (RUN / DRAIN / SWITCH)
//   SEL_WIDE/NARROW : values driven onto the interconnect wide/narrow select
//   DEFAULT_*       : default bus geometry used by the interface and the top
package maestro_hci_package;

   localparam int unsigned DEFAULT_DW = 128;
   localparam int unsigned DEFAULT_AW = 32;
   localparam int unsigned DEFAULT_BW = 8;
   localparam int unsigned DEFAULT_WW = 32;
   localparam int unsigned DEFAULT_UW = 1;

   localparam logic SEL_WIDE   = 1'b1;
   localparam logic SEL_NARROW = 1'b0;

   typedef enum logic [1:0] {
      MS_RUN,
      MS_DRAIN,
      MS_SWITCH
   } mode_sw_state_t;

endpackage

// File: rtl/hci_core_intf.sv
// Request/response bundle between the HWPE streamer and the interconnect.
//   master : drives req/add/wen/data/be/user, receives gnt/r_data/r_valid/r_user
//   slave  : the mirror image
interface hci_core_intf #(
   parameter int unsigned DW = maestro_hci_package::DEFAULT_DW,
   parameter int unsigned AW = maestro_hci_package::DEFAULT_AW,
   parameter int unsigned BW = maestro_hci_package::DEFAULT_BW,
   parameter int unsigned UW = maestro_hci_package::DEFAULT_UW
);
   localparam int unsigned BEW = DW / BW;

   logic            req;
   logic            gnt;
   logic [AW-1:0]   add;
   logic            wen;
   logic [DW-1:0]   data;
   logic [BEW-1:0]  be;
   logic [UW-1:0]   user;
   logic [DW-1:0]   r_data;
   logic            r_valid;
   logic [UW-1:0]   r_user;

   modport master (
      output req, add, wen, data, be, user,
      input  gnt, r_data, r_valid, r_user
   );

   modport slave (
      input  req, add, wen, data, be, user,
      output gnt, r_data, r_valid, r_user
   );

endinterface

// File: rtl/maestro_hci_outstanding_cnt.sv
// Counts granted-but-unanswered transactions.
//   clk_i/rst_i/clear_i : clock, synchronous active-high reset and soft clear
//   inc_i / dec_i       : request granted / response (r_valid) seen
//   cnt_o               : live outstanding count
//   full_o / empty_o    : cnt_o == MAX / cnt_o == 0
//   underflow_o         : response with nothing outstanding
//   dec_ok_o            : this cycle's response decrements cnt_o
// Responses still in flight when reset/clear hits are remembered in stale_q
// and absorbed silently when they eventually arrive.
module maestro_hci_outstanding_cnt #(
   parameter int unsigned MAX = 4,
   localparam int unsigned CW = $clog2(MAX + 1)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          clear_i,
   input  logic          inc_i,
   input  logic          dec_i,
   output logic [CW-1:0] cnt_o,
   output logic          full_o,
   output logic          empty_o,
   output logic          underflow_o,
   output logic          dec_ok_o
);

   localparam int unsigned SW   = CW + 1;
   localparam int unsigned SMAX = (2 ** SW) - 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic [SW-1:0] stale_q, stale_d, stale_rst;
   logic [SW:0]   tot_c;
   logic          stale_hit;

   // Oldest responses belong to pre-reset transactions; consume those first.
   assign stale_hit   = dec_i & (stale_q != '0);
   assign empty_o     = (cnt_q == '0);
   assign full_o      = (cnt_q == CW'(MAX));
   assign dec_ok_o    = dec_i & ~stale_hit & ~empty_o;
   assign underflow_o = dec_i & ~stale_hit & empty_o;
   assign cnt_o       = cnt_q;

   // Next count; simultaneous inc and applied dec cancel.
   always_comb begin
      cnt_d   = cnt_q;
      stale_d = stale_q;
      if (inc_i & ~dec_ok_o) begin
         cnt_d = cnt_q + CW'(1);
      end else if (dec_ok_o & ~inc_i) begin
         cnt_d = cnt_q - CW'(1);
      end
      if (stale_hit) begin
         stale_d = stale_q - SW'(1);
      end
   end

   // Everything still in flight after a reset cycle becomes stale (saturating).
   always_comb begin
      tot_c     = {1'b0, stale_d} + (SW + 1)'(cnt_d);
      stale_rst = (tot_c > (SW + 1)'(SMAX)) ? SW'(SMAX) : tot_c[SW-1:0];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i | clear_i) begin
         cnt_q   <= '0;
         stale_q <= stale_rst;
      end else begin
         cnt_q   <= cnt_d;
         stale_q <= stale_d;
      end
   end

endmodule

// File: rtl/maestro_hci_mode_switch_ctrl.sv
// Wide/narrow mode switch in front of the maestro HWPE interconnect.
// Stalls new requests, drains outstanding responses, then flips sel_o.
//   clk_i, rst_i, clear_i : clock, synchronous active-high reset / soft clear
//   mode_valid_i, mode_i  : mode-change request and requested sel value
//   mode_ready_o          : request accepted (same mode) or completed (SWITCH)
//   sel_o                 : registered wide(1)/narrow(0) select
//   busy_o                : switch in progress (DRAIN or SWITCH)
//   err_o                 : sticky error (response underflow, illegal narrow be)
//   in                    : hci_core slave port from the streamer
//   out                   : hci_core master port to the interconnect
module maestro_hci_mode_switch_ctrl
   import maestro_hci_package::*;
#(
   parameter int unsigned DWH             = DEFAULT_DW,
   parameter int unsigned DWH_SUB         = DEFAULT_DW,
   parameter int unsigned AWH             = DEFAULT_AW,
   parameter int unsigned BWH             = DEFAULT_BW,
   parameter int unsigned WWH             = DEFAULT_WW,
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter logic        SEL_RESET       = SEL_WIDE
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clear_i,
   input  logic         mode_valid_i,
   input  logic         mode_i,
   output logic         mode_ready_o,
   output logic         sel_o,
   output logic         busy_o,
   output logic         err_o,
   hci_core_intf.slave  in,
   hci_core_intf.master out
);

   localparam int unsigned CW  = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned BEW = DWH / BWH;
   localparam int unsigned BEW_SUB = DWH_SUB / BWH;
   localparam logic [DWH-1:0] DATA_MASK = {DWH{1'b1}} >> (DWH - DWH_SUB);
   localparam logic [BEW-1:0] BE_MASK   = {BEW{1'b1}} >> (BEW - BEW_SUB);

   if ((DWH_SUB > DWH) || ((DWH_SUB % WWH) != 0) || ((DWH_SUB % BWH) != 0) ||
       (MAX_OUTSTANDING < 1)) begin : g_cfg_err
      $error("maestro_hci_mode_switch_ctrl: illegal parameter set");
   end

   mode_sw_state_t state_q, state_d;
   logic           sel_q, sel_d;
   logic           mode_q, mode_d;
   logic           err_q, err_d;

   logic           soft_rst_c;
   logic           switch_pending_c;
   logic           pass_c;
   logic           inc_c;
   logic           be_err_c;
   logic [AWH-1:0] add_c;

   logic [CW-1:0]  cnt;
   logic           cnt_full, cnt_empty, cnt_underflow, cnt_dec_ok;

   assign soft_rst_c       = rst_i | clear_i;
   assign switch_pending_c = mode_valid_i & (mode_i != sel_q);
   assign pass_c           = ~soft_rst_c & (state_q == MS_RUN) & ~cnt_full & ~switch_pending_c;

   // Handshake gating: a request is only forwarded when it may also be granted.
   assign out.req = in.req & pass_c;
   assign in.gnt  = out.gnt & pass_c;
   assign inc_c   = in.req & out.gnt & pass_c;

   assign add_c      = in.add;
   assign out.add    = add_c;
   assign out.wen    = in.wen;
   assign out.user   = in.user;
   assign in.r_valid = out.r_valid;
   assign in.r_user  = out.r_user;

   // Lane masking in narrow mode.
   assign out.data  = (sel_q == SEL_WIDE) ? in.data    : (in.data & DATA_MASK);
   assign out.be    = (sel_q == SEL_WIDE) ? in.be      : (in.be & BE_MASK);
   assign in.r_data = (sel_q == SEL_WIDE) ? out.r_data : (out.r_data & DATA_MASK);

   assign be_err_c = (sel_q == SEL_NARROW) & inc_c & ((in.be & ~BE_MASK) != '0);

   maestro_hci_outstanding_cnt #(
      .MAX (MAX_OUTSTANDING)
   ) u_cnt (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .clear_i     (clear_i),
      .inc_i       (inc_c),
      .dec_i       (out.r_valid),
      .cnt_o       (cnt),
      .full_o      (cnt_full),
      .empty_o     (cnt_empty),
      .underflow_o (cnt_underflow),
      .dec_ok_o    (cnt_dec_ok)
   );

   // Next-state and mode handshake.
   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      mode_d       = mode_q;
      err_d        = err_q | cnt_underflow | be_err_c;
      mode_ready_o = 1'b0;
      unique case (state_q)
         MS_RUN: begin
            if (switch_pending_c) begin
               mode_d  = mode_i;
               state_d = MS_DRAIN;
            end else if (mode_valid_i) begin
               mode_ready_o = ~soft_rst_c;
            end
         end
         MS_DRAIN: begin
            // A response this cycle taking the count 1 -> 0 also completes the drain.
            if (cnt_empty | ((cnt == CW'(1)) & cnt_dec_ok)) begin
               state_d = MS_SWITCH;
            end
         end
         MS_SWITCH: begin
            sel_d        = mode_q;
            mode_ready_o = ~soft_rst_c;
            state_d      = MS_RUN;
         end
         default: state_d = MS_RUN;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (soft_rst_c) begin
         state_q <= MS_RUN;
         sel_q   <= SEL_RESET;
         mode_q  <= SEL_RESET;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         mode_q  <= mode_d;
         err_q   <= err_d;
      end
   end

   assign sel_o  = sel_q;
   assign err_o  = err_q;
   assign busy_o = (state_q != MS_RUN);

endmodule

// File: tb/tb_maestro_hci_mode_switch_ctrl.sv
// Bench for maestro_hci_mode_switch_ctrl: directed scenarios plus random traffic,
// compared every cycle against a transaction-level model of the switch rules.
module tb_maestro_hci_mode_switch_ctrl;

   localparam int unsigned DW   = 128;
   localparam int unsigned SUB  = 64;
   localparam int unsigned AW   = 32;
   localparam int unsigned BW   = 8;
   localparam int unsigned BEW  = DW / BW;
   localparam int unsigned UW   = 1;
   localparam int unsigned MAXO = 4;
   localparam int          STALE_SAT = 15;

   logic clk = 1'b0;
   logic rst, clr, mv, mi;
   logic mready, sel, busy, err;

   hci_core_intf #(.DW(DW), .AW(AW), .BW(BW), .UW(UW)) in_if ();
   hci_core_intf #(.DW(DW), .AW(AW), .BW(BW), .UW(UW)) out_if ();

   maestro_hci_mode_switch_ctrl #(
      .DWH             (DW),
      .DWH_SUB         (SUB),
      .AWH             (AW),
      .BWH             (BW),
      .WWH             (32),
      .MAX_OUTSTANDING (MAXO),
      .SEL_RESET       (1'b1)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .clear_i      (clr),
      .mode_valid_i (mv),
      .mode_i       (mi),
      .mode_ready_o (mready),
      .sel_o        (sel),
      .busy_o       (busy),
      .err_o        (err),
      .in           (in_if),
      .out          (out_if)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Model: outstanding responses, stale (pre-reset) responses, switch phase.
   int   m_cnt, m_stale, m_phase;   // phase 0 = running, 1 = draining, 2 = switching
   logic m_sel, m_err, m_target, m_exp_ready;
   logic [DW-1:0]  dmask;
   logic [BEW-1:0] bmask;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare all outputs at the negedge, then advance the model for the coming posedge.
   task automatic half1();
      logic pending, pass, rstc, req_e, gnt_e, rdy_e, granted, dec, spur, nerr;
      int ncnt, nst;
      logic [DW-1:0]  dexp, rexp;
      logic [BEW-1:0] bexp;
      @(negedge clk);
      rstc    = rst | clr;
      pending = mv && (mi != m_sel);
      pass    = !rstc && (m_phase == 0) && (m_cnt < MAXO) && !pending;
      req_e   = in_if.req && pass;
      gnt_e   = out_if.gnt && pass;
      rdy_e   = !rstc && (((m_phase == 0) && mv && !pending) || (m_phase == 2));
      dexp    = m_sel ? in_if.data : (in_if.data & dmask);
      bexp    = m_sel ? in_if.be : (in_if.be & bmask);
      rexp    = m_sel ? out_if.r_data : (out_if.r_data & dmask);
      chk("out_req",    DW'(out_if.req),    DW'(req_e));
      chk("in_gnt",     DW'(in_if.gnt),     DW'(gnt_e));
      chk("out_add",    DW'(out_if.add),    DW'(in_if.add));
      chk("out_wen",    DW'(out_if.wen),    DW'(in_if.wen));
      chk("out_user",   DW'(out_if.user),   DW'(in_if.user));
      chk("out_data",   out_if.data,        dexp);
      chk("out_be",     DW'(out_if.be),     DW'(bexp));
      chk("in_r_valid", DW'(in_if.r_valid), DW'(out_if.r_valid));
      chk("in_r_user",  DW'(in_if.r_user),  DW'(out_if.r_user));
      chk("in_r_data",  in_if.r_data,       rexp);
      chk("mode_ready", DW'(mready),        DW'(rdy_e));
      chk("busy",       DW'(busy),          DW'(m_phase != 0));
      chk("sel",        DW'(sel),           DW'(m_sel));
      chk("err",        DW'(err),           DW'(m_err));
      m_exp_ready = rdy_e;

      granted = req_e && out_if.gnt;
      dec  = 1'b0;
      spur = 1'b0;
      nst  = m_stale;
      if (out_if.r_valid) begin
         if (m_stale > 0)    nst--;
         else if (m_cnt > 0) dec = 1'b1;
         else                spur = 1'b1;
      end
      ncnt = m_cnt + (granted ? 1 : 0) - (dec ? 1 : 0);
      nerr = !m_sel && granted && ((in_if.be & ~bmask) != '0);
      if (rstc) begin
         m_phase = 0;
         m_sel   = 1'b1;
         m_err   = 1'b0;
         m_cnt   = 0;
         m_stale = (nst + ncnt > STALE_SAT) ? STALE_SAT : nst + ncnt;
      end else begin
         m_err   = m_err | spur | nerr;
         m_cnt   = ncnt;
         m_stale = nst;
         case (m_phase)
            0: if (pending) begin m_phase = 1; m_target = mi; end
            1: if (ncnt == 0) m_phase = 2;
            default: begin m_phase = 0; m_sel = m_target; end
         endcase
      end
   endtask

   task automatic half2();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc();
      half1();
      half2();
   endtask

   task automatic idle_inputs();
      rst = 1'b0; clr = 1'b0; mv = 1'b0; mi = 1'b0;
      in_if.req = 1'b0; in_if.add = '0; in_if.wen = 1'b0; in_if.data = '0;
      in_if.be = '0; in_if.user = '0;
      out_if.gnt = 1'b0; out_if.r_data = '0; out_if.r_valid = 1'b0; out_if.r_user = '0;
   endtask

   task automatic do_switch(input logic m);
      mv = 1'b1;
      mi = m;
      for (int k = 0; k < 20; k++) begin
         half1();
         if (m_exp_ready) begin
            half2();
            mv = 1'b0;
            return;
         end
         half2();
      end
      chk("switch_timeout", DW'(1), DW'(0));
      mv = 1'b0;
   endtask

   initial begin
      logic [DW-1:0] ones;
      bit drop;
      int hold;
      ones  = '1;
      dmask = '0;
      for (int i = 0; i < SUB; i++) dmask[i] = 1'b1;
      bmask = '0;
      for (int i = 0; i < SUB / BW; i++) bmask[i] = 1'b1;
      m_cnt = 0; m_stale = 0; m_phase = 0; m_sel = 1'b1; m_err = 1'b0;
      m_target = 1'b1; m_exp_ready = 1'b0;
      idle_inputs();
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Reset then idle.
      cyc(); cyc();
      rst = 1'b0;
      half1();
      chk("t1_sel", DW'(sel), DW'(1));
      chk("t1_gnt", DW'(in_if.gnt), DW'(0));
      chk("t1_err", DW'(err), DW'(0));
      chk("t1_busy", DW'(busy), DW'(0));
      chk("t1_ready", DW'(mready), DW'(0));
      half2();

      // Switch to narrow with an empty pipe.
      mv = 1'b1; mi = 1'b0;
      half1(); chk("t2_busy_t", DW'(busy), DW'(0)); chk("t2_rdy_t", DW'(mready), DW'(0)); half2();
      half1(); chk("t2_busy_t1", DW'(busy), DW'(1)); chk("t2_rdy_t1", DW'(mready), DW'(0)); half2();
      half1(); chk("t2_rdy_t2", DW'(mready), DW'(1)); chk("t2_sel_t2", DW'(sel), DW'(1)); half2();
      mv = 1'b0;
      half1(); chk("t2_sel_t3", DW'(sel), DW'(0)); chk("t2_busy_t3", DW'(busy), DW'(0)); half2();
      do_switch(1'b1);

      // Drain under load.
      in_if.req = 1'b1; out_if.gnt = 1'b1; in_if.be = 16'h000F;
      in_if.data = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < 4; i++) begin
         half1(); chk("t3_fill_gnt", DW'(in_if.gnt), DW'(1)); half2();
      end
      mv = 1'b1; mi = 1'b0;
      for (int i = 0; i < 3; i++) begin
         half1(); chk("t3_stall_gnt", DW'(in_if.gnt), DW'(0)); half2();
      end
      out_if.r_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         half1(); chk("t3_drain_gnt", DW'(in_if.gnt), DW'(0)); chk("t3_drain_busy", DW'(busy), DW'(1)); half2();
      end
      out_if.r_valid = 1'b0;
      half1(); chk("t3_sw_rdy", DW'(mready), DW'(1)); chk("t3_sw_gnt", DW'(in_if.gnt), DW'(0)); half2();
      mv = 1'b0;
      half1(); chk("t3_sel", DW'(sel), DW'(0)); chk("t3_resume_gnt", DW'(in_if.gnt), DW'(1)); half2();

      // Narrow masking and illegal upper byte enables.
      in_if.data = ones; in_if.be = 16'hFFFF;
      half1();
      chk("t4_be", DW'(out_if.be), DW'(16'h00FF));
      chk("t4_data", out_if.data, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF);
      chk("t4_gnt", DW'(in_if.gnt), DW'(1));
      chk("t4_err_pre", DW'(err), DW'(0));
      half2();
      in_if.req = 1'b0;
      half1(); chk("t4_err", DW'(err), DW'(1)); half2();
      out_if.r_valid = 1'b1; out_if.r_data = ones;
      half1(); chk("t4_rdata", in_if.r_data, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF); half2();
      cyc();
      out_if.r_valid = 1'b0;

      // Backpressure at the outstanding limit.
      idle_inputs();
      rst = 1'b1; cyc(); rst = 1'b0;
      in_if.req = 1'b1; out_if.gnt = 1'b1; in_if.be = 16'h000F;
      for (int i = 0; i < 4; i++) cyc();
      half1(); chk("t5_full_gnt", DW'(in_if.gnt), DW'(0)); half2();
      out_if.r_valid = 1'b1;
      half1(); chk("t5_rv_gnt", DW'(in_if.gnt), DW'(0)); half2();
      out_if.r_valid = 1'b0;
      half1(); chk("t5_resume_gnt", DW'(in_if.gnt), DW'(1)); half2();
      out_if.r_valid = 1'b1;
      half1(); chk("t5_rv2_gnt", DW'(in_if.gnt), DW'(0)); half2();
      half1(); chk("t5_both_gnt", DW'(in_if.gnt), DW'(1)); half2();
      out_if.r_valid = 1'b0;
      half1(); chk("t5_last_gnt", DW'(in_if.gnt), DW'(1)); half2();
      half1(); chk("t5_refull_gnt", DW'(in_if.gnt), DW'(0)); half2();
      in_if.req = 1'b0; out_if.r_valid = 1'b1;
      for (int i = 0; i < 4; i++) cyc();
      out_if.r_valid = 1'b0;

      // Robustness: spurious response, reset during drain.
      half1(); chk("t6_err_clean", DW'(err), DW'(0)); half2();
      out_if.r_valid = 1'b1; cyc(); out_if.r_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         half1(); chk("t6_err_sticky", DW'(err), DW'(1)); half2();
      end
      rst = 1'b1; cyc(); rst = 1'b0;
      in_if.req = 1'b1; out_if.gnt = 1'b1;
      cyc(); cyc();
      in_if.req = 1'b0; mv = 1'b1; mi = 1'b0;
      cyc();
      half1(); chk("t6_drain_busy", DW'(busy), DW'(1)); half2();
      rst = 1'b1; cyc(); rst = 1'b0; mv = 1'b0;
      half1();
      chk("t6_rst_busy", DW'(busy), DW'(0));
      chk("t6_rst_sel", DW'(sel), DW'(1));
      chk("t6_rst_err", DW'(err), DW'(0));
      half2();
      out_if.r_valid = 1'b1; cyc(); cyc(); out_if.r_valid = 1'b0;
      half1(); chk("t6_late_rv_err", DW'(err), DW'(0)); half2();

      // Random traffic with mode requests, resets and clears.
      idle_inputs();
      hold = 0;
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 299) == 0);
         clr = ($urandom_range(0, 299) == 0);
         if (!mv && ($urandom_range(0, 24) == 0)) begin
            mv = 1'b1;
            mi = 1'($urandom_range(0, 1));
            hold = 0;
         end
         in_if.req  = 1'($urandom_range(0, 1));
         in_if.add  = $urandom;
         in_if.wen  = 1'($urandom_range(0, 1));
         in_if.data = {$urandom, $urandom, $urandom, $urandom};
         in_if.be   = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
         in_if.user = 1'($urandom_range(0, 1));
         out_if.gnt = ($urandom_range(0, 9) < 7);
         if (m_cnt + m_stale > 0) out_if.r_valid = ($urandom_range(0, 9) < 4);
         else                     out_if.r_valid = ($urandom_range(0, 199) == 0);
         out_if.r_data = {$urandom, $urandom, $urandom, $urandom};
         out_if.r_user = 1'($urandom_range(0, 1));
         half1();
         drop = 1'b0;
         if (mv) begin
            hold++;
            if (m_exp_ready) begin
               drop = 1'b1;
            end else if (hold > 64) begin
               chk("rand_mode_timeout", DW'(hold), DW'(0));
               drop = 1'b1;
            end
         end
         half2();
         if (drop) mv = 1'b0;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
